grid_io_bank: RTL and testbench

Parametrised I/O bank tile: NUM_IO GPIO subtiles sharing one configuration-chain segment, with a shift counter, length check and shadow-commit stage. Configuration bits shift through a staging chain without disturbing the pads. They reach the pads only on an explicit commit of a complete, correctly sized bitstream. The bank sits on the fabric perimeter between the routing channel (inpad/outpad pins) and the GPIO pads, and replaces the fixed two-subtile bottom I/O grid.

---
 rtl/grid_io_bank_pkg.sv | 30 +++
 rtl/grid_io_bank_if.sv | 35 +++
 rtl/grid_io_bank_pad_cell.sv | 16 +
 rtl/grid_io_bank.sv | 115 +++++++++++
 tb/tb_grid_io_bank.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/grid_io_bank_pkg.sv
// Shared types for the I/O bank tile: per-subtile mode encoding and the
// configuration-load state. Mode bit 1 enables the pad driver and mode bit 0
// enables the pad-to-fabric path, so each mode is just a pair of enables.
package grid_io_pkg;

  localparam int IO_CFG_BITS = 2;

  typedef enum logic [1:0] {
    DISABLED = 2'b00,
    INPUT    = 2'b01,
    OUTPUT   = 2'b10,
    LOOPBACK = 2'b11
  } io_mode_t;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    FULL,
    OVER
  } cfg_state_t;

  function automatic logic mode_drives(io_mode_t m);
    return m[1];
  endfunction

  function automatic logic mode_listens(io_mode_t m);
    return m[0];
  endfunction

endpackage

// File: rtl/grid_io_bank_if.sv
// Fabric/config-chain side of the I/O bank tile.
// Ports: ccff_head/ccff_shift_en/cfg_commit and outpad into the bank; inpad,
// ccff_tail and the cfg_count/cfg_full/cfg_valid/cfg_err status out of it.
interface grid_io_bank_if #(
  parameter int NUM_IO = 2
);
  import grid_io_pkg::*;

  localparam int TOTAL = NUM_IO * IO_CFG_BITS;
  localparam int CW    = $clog2(TOTAL + 1);

  logic              ccff_head;
  logic              ccff_shift_en;
  logic              cfg_commit;
  logic [NUM_IO-1:0] outpad;
  logic [NUM_IO-1:0] inpad;
  logic              ccff_tail;
  logic [CW-1:0]     cfg_count;
  logic              cfg_full;
  logic              cfg_valid;
  logic              cfg_err;

  // master: fabric / config controller side
  modport master (
    output ccff_head, ccff_shift_en, cfg_commit, outpad,
    input  inpad, ccff_tail, cfg_count, cfg_full, cfg_valid, cfg_err
  );

  // slave: the bank itself
  modport slave (
    input  ccff_head, ccff_shift_en, cfg_commit, outpad,
    output inpad, ccff_tail, cfg_count, cfg_full, cfg_valid, cfg_err
  );

endinterface

// File: rtl/grid_io_bank_pad_cell.sv
// One GPIO subtile: turns a 2-bit mode into a pad tristate and an inpad gate.
// Ports: mode (active config), outpad (fabric data), pad (physical, inout),
// inpad (to fabric). Purely combinational; the pad input path has no register.
module grid_io_pad_cell
  import grid_io_pkg::*;
(
  input  io_mode_t mode,
  input  logic     outpad,
  inout  wire      pad,
  output logic     inpad
);

  assign pad   = mode_drives(mode) ? outpad : 1'bz;
  assign inpad = mode_listens(mode) & pad;

endmodule

// File: rtl/grid_io_bank.sv
// I/O bank tile: NUM_IO pad subtiles behind one configuration-chain segment.
// Ports: prog_clk, pReset (async, active-high), bus (grid_io_bank_if.slave:
// chain in/out, commit, fabric data, load status), gfpga_pad_GPIO_PAD (pads).
// Bits shift into a staging chain; only a commit of exactly TOTAL bits copies
// it into the active register that drives the pads, so pads never see a
// partially shifted bitstream.
module grid_io_bank
  import grid_io_pkg::*;
#(
  parameter int NUM_IO = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  grid_io_bank_if.slave     bus,
  inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD
);

  localparam int TOTAL = NUM_IO * IO_CFG_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(TOTAL);

  logic [TOTAL-1:0] chain_q, chain_d;
  logic [TOTAL-1:0] active_q, active_d;
  logic [CW-1:0]    count_q, count_d;
  cfg_state_t       state_q, state_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [CW-1:0]     count_inc;
  logic [NUM_IO-1:0] inpad_w;

  assign count_inc = count_q + CW'(1);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      chain_q  <= '0;
      active_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      active_q <= active_d;
      count_q  <= count_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Commit has priority: a shift in the same cycle is dropped so the commit
  // acts on exactly the contents that were checked as complete.
  always_comb begin
    chain_d  = chain_q;
    active_d = active_q;
    count_d  = count_q;
    state_d  = state_q;
    valid_d  = valid_q;
    err_d    = err_q;

    if (bus.cfg_commit) begin
      if (state_q == FULL) begin
        active_d = chain_q;
        valid_d  = 1'b1;
        count_d  = '0;
        state_d  = EMPTY;
      end else begin
        err_d = 1'b1;
        // An overflowed load is abandoned so the next load starts clean.
        if (state_q == OVER) begin
          count_d = '0;
          state_d = EMPTY;
        end
      end
    end else if (bus.ccff_shift_en) begin
      // The chain always shifts, even past full, so tiles downstream of
      // ccff_tail keep loading.
      chain_d = {chain_q[TOTAL-2:0], bus.ccff_head};
      unique case (state_q)
        EMPTY, LOADING: begin
          count_d = count_inc;
          state_d = (count_inc == COUNT_MAX) ? FULL : LOADING;
        end
        FULL: begin
          state_d = OVER;
          err_d   = 1'b1;
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    grid_io_pad_cell u_pad (
      .mode   (io_mode_t'(active_q[i*IO_CFG_BITS +: IO_CFG_BITS])),
      .outpad (bus.outpad[i]),
      .pad    (gfpga_pad_GPIO_PAD[i]),
      .inpad  (inpad_w[i])
    );
  end

  assign bus.inpad     = inpad_w;
  assign bus.ccff_tail = chain_q[TOTAL-1];
  assign bus.cfg_count = count_q;
  assign bus.cfg_full  = (state_q == FULL);
  assign bus.cfg_valid = valid_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_grid_io_bank.sv
module tb_grid_io_bank;

  localparam int NUM_IO = 2;

  logic prog_clk;
  logic pReset;

  grid_io_bank_if #(.NUM_IO(NUM_IO)) bus ();

  wire  [NUM_IO-1:0] pad_w;
  logic [NUM_IO-1:0] tb_pad_en;
  logic [NUM_IO-1:0] tb_pad_val;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_tb_pad
    assign pad_w[i] = tb_pad_en[i] ? tb_pad_val[i] : 1'bz;
  end

  grid_io_bank #(.NUM_IO(NUM_IO)) dut (
    .prog_clk           (prog_clk),
    .pReset             (pReset),
    .bus                (bus),
    .gfpga_pad_GPIO_PAD (pad_w)
  );

  int checks   = 0;
  int failures = 0;

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    bus.ccff_head     = b;
    bus.ccff_shift_en = 1'b1;
    step();
    bus.ccff_shift_en = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    step();
    bus.cfg_commit = 1'b0;
  endtask

  // Pads count as undriven if the bench can hold them at 0 while outpad is 1.
  task automatic check_pads_z(input string tag);
    tb_pad_en  = 2'b11;
    tb_pad_val = 2'b00;
    bus.outpad = 2'b11;
    #1;
    check({tag, "_pad"}, 32'(pad_w), 32'h0);
    check({tag, "_inpad"}, 32'(bus.inpad), 32'h0);
  endtask

  initial begin
    pReset            = 1'b1;
    bus.ccff_head     = 1'b0;
    bus.ccff_shift_en = 1'b0;
    bus.cfg_commit    = 1'b0;
    bus.outpad        = 2'b00;
    tb_pad_en         = 2'b11;
    tb_pad_val        = 2'b00;
    #2;

    // ---- reset state ----
    check("rst_count", 32'(bus.cfg_count), 32'd0);
    check("rst_full",  32'(bus.cfg_full),  32'd0);
    check("rst_valid", 32'(bus.cfg_valid), 32'd0);
    check("rst_err",   32'(bus.cfg_err),   32'd0);
    check("rst_tail",  32'(bus.ccff_tail), 32'd0);
    check_pads_z("rst");
    step();
    pReset = 1'b0;
    step();

    // ---- load 1,0,0,1 and commit: ch1 OUTPUT, ch0 INPUT ----
    shift_bit(1'b1); check("ld_cnt1", 32'(bus.cfg_count), 32'd1);
    shift_bit(1'b0); check("ld_cnt2", 32'(bus.cfg_count), 32'd2);
    shift_bit(1'b0); check("ld_cnt3", 32'(bus.cfg_count), 32'd3);
    check("ld_full3", 32'(bus.cfg_full), 32'd0);
    shift_bit(1'b1);
    check("ld_cnt4",  32'(bus.cfg_count), 32'd4);
    check("ld_full4", 32'(bus.cfg_full),  32'd1);
    check("ld_tail4", 32'(bus.ccff_tail), 32'd1);
    check_pads_z("ld_prec");
    commit();
    check("cm_valid", 32'(bus.cfg_valid), 32'd1);
    check("cm_count", 32'(bus.cfg_count), 32'd0);
    check("cm_full",  32'(bus.cfg_full),  32'd0);
    check("cm_err",   32'(bus.cfg_err),   32'd0);
    tb_pad_en  = 2'b01;
    tb_pad_val = 2'b01;
    bus.outpad = 2'b10;
    #1;
    check("cm_pad1_hi", 32'(pad_w[1]),     32'd1);
    check("cm_in0_hi",  32'(bus.inpad),    32'b01);
    tb_pad_val = 2'b00;
    bus.outpad = 2'b01;
    #1;
    check("cm_pad1_lo", 32'(pad_w[1]),     32'd0);
    check("cm_in0_lo",  32'(bus.inpad),    32'b00);

    // ---- reshift 1,1,1,1: pads hold old modes while shifting ----
    for (int k = 0; k < 4; k++) begin
      shift_bit(1'b1);
      tb_pad_val = 2'(k & 1);
      bus.outpad = (k & 1) ? 2'b00 : 2'b10;
      #1;
      check($sformatf("rs_pad1_%0d", k), 32'(pad_w[1]), 32'((k & 1) ? 0 : 1));
      check($sformatf("rs_in_%0d", k),   32'(bus.inpad), 32'(k & 1));
    end
    check("rs_full", 32'(bus.cfg_full), 32'd1);

    // ---- shift + commit together while FULL: commit wins, shift dropped ----
    bus.ccff_head     = 1'b0;
    bus.ccff_shift_en = 1'b1;
    bus.cfg_commit    = 1'b1;
    step();
    bus.ccff_shift_en = 1'b0;
    bus.cfg_commit    = 1'b0;
    check("sc_count", 32'(bus.cfg_count), 32'd0);
    check("sc_err",   32'(bus.cfg_err),   32'd0);
    check("sc_valid", 32'(bus.cfg_valid), 32'd1);
    tb_pad_en  = 2'b00;
    bus.outpad = 2'b10;
    #1;
    check("lb_pad_10", 32'(pad_w),     32'b10);
    check("lb_in_10",  32'(bus.inpad), 32'b10);
    bus.outpad = 2'b01;
    #1;
    check("lb_pad_01", 32'(pad_w),     32'b01);
    check("lb_in_01",  32'(bus.inpad), 32'b01);

    // Chain stayed 1111, so three zero shifts leave an original 1 at the tail.
    shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
    check("sc_tail", 32'(bus.ccff_tail), 32'd1);

    // ---- short load (3 bits) commit: rejected, active unchanged ----
    commit();
    check("sh_err",   32'(bus.cfg_err),   32'd1);
    check("sh_count", 32'(bus.cfg_count), 32'd3);
    check("sh_valid", 32'(bus.cfg_valid), 32'd1);
    bus.outpad = 2'b10;
    #1;
    check("sh_pad", 32'(pad_w),     32'b10);
    check("sh_in",  32'(bus.inpad), 32'b10);

    // ---- async reset mid-shift ----
    bus.ccff_head     = 1'b1;
    bus.ccff_shift_en = 1'b1;
    #3;
    pReset = 1'b1;
    #1;
    check("ar_count", 32'(bus.cfg_count), 32'd0);
    check("ar_valid", 32'(bus.cfg_valid), 32'd0);
    check("ar_err",   32'(bus.cfg_err),   32'd0);
    check("ar_tail",  32'(bus.ccff_tail), 32'd0);
    check_pads_z("ar");
    bus.ccff_shift_en = 1'b0;
    step();
    pReset = 1'b0;
    step();

    // ---- overflow: shift 1,1,0,1,0 ----
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
    check("ov_full4", 32'(bus.cfg_full),  32'd1);
    check("ov_tail4", 32'(bus.ccff_tail), 32'd1);
    shift_bit(1'b0);
    check("ov_count", 32'(bus.cfg_count), 32'd4);
    check("ov_full",  32'(bus.cfg_full),  32'd0);
    check("ov_err",   32'(bus.cfg_err),   32'd1);
    check("ov_tail5", 32'(bus.ccff_tail), 32'd1);
    commit();
    check("ovc_valid", 32'(bus.cfg_valid), 32'd0);
    check("ovc_count", 32'(bus.cfg_count), 32'd0);
    check("ovc_err",   32'(bus.cfg_err),   32'd1);
    check_pads_z("ovc");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
